alu_rr_arbiter: RTL and testbench
=================================

// Module: alu_rr_arbiter
// PURPOSE
//  Shares one 6-bit combinational ALU between two requesters (port 0, port 1) with round-robin arbitration.
//  Each requester presents {op, a, b} under a valid/ready handshake. The granted operation is evaluated
//  and its result registered into a single-entry response buffer tagged with the requester id.
//  Sits between the tile I/O sequencing logic and the shared ALU datapath.
// PARAMETERS
//  WIDTH  6  operand/result width; shift amount is b[$clog2(WIDTH)-1:0]
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      synchronous reset, active-high
//  req0_valid  in   1      port 0 request valid
//  req0_ready  out  1      port 0 accepted this cycle when valid&ready
//  req0_op     in   4      port 0 ALU control code
//  req0_a      in   WIDTH  port 0 operand A
//  req0_b      in   WIDTH  port 0 operand B
//  req1_valid, req1_ready, req1_op, req1_a, req1_b   same as port 0, for port 1
//  rsp_valid   out  1      response buffer holds a result
//  rsp_ready   in   1      consumer takes the response when rsp_valid&rsp_ready
//  rsp_id      out  1      requester that issued the result
//  rsp_out     out  WIDTH  ALU result
//  rsp_carry   out  1      carry/borrow (ADD: sum[WIDTH]; SUB: dif[WIDTH]; else 0)
//  rsp_zero    out  1      rsp_out == 0
//  rsp_illegal out  1      op was not a defined code (result forced to 0)
// BEHAVIOUR
//  - Reset: all rsp_* outputs 0, state EMPTY, last_grant=1 (port 0 wins first tie). Reset mid-operation
//    discards the buffered result; no request is accepted in a cycle where rst=1.
//  - Op codes: AND=0000, OR=0001, ADD=0010, SLL=0011, XOR=0100, SRL=0101, SUB=0110, SRA=0111, SLT=1000 (signed).
//    All other codes: out=0, carry=0, zero=1, illegal=1.
//  - Shifts: amount sh=b[2:0]. If sh>=WIDTH: SLL/SRL give 0; SRA gives WIDTH copies of a[WIDTH-1].
//  - Arithmetic: ADD/SUB on zero-extended (WIDTH+1)-bit operands; SUB carry=1 means borrow (a<b unsigned).
//  - FSM, two states. EMPTY: rsp_valid=0. FULL: rsp_valid=1 and rsp_* stable until taken.
//    EMPTY->FULL on accept; FULL->EMPTY on take without accept; FULL->FULL on take with accept
//    (buffer reloaded, back-to-back); FULL with no take: hold, no accept.
//  - can_accept = (state==EMPTY) | rsp_ready. Grant is combinational from the valids:
//    only one valid -> that port; both valid -> port != last_grant; none -> no grant.
//  - reqN_ready = can_accept & grant==N. Never high on both ports in the same cycle. Ready may depend on
//    valid (grant). A requester must hold valid and payload stable until accepted.
//  - last_grant updates only on an actual accept (valid&ready), not on grant without accept.
//  - Latency: accept at edge N -> rsp_valid with result visible after edge N. Throughput: 1 op/cycle
//    while rsp_ready=1.
//  - Fairness: with both ports continuously valid and rsp_ready=1, grants strictly alternate.
//    A waiting port is served within 2 accepts.
// STRUCTURE
//  - Shared include alu_defs.vh: op-code localparams, ALU_W default, RSP_EMPTY/RSP_FULL state encodings.
//  - Sub-module alu_core (combinational): op, a, b -> out, carry, zero, illegal. Instantiated once.
//    The arbiter/FSM and response register live in alu_rr_arbiter.
// TESTING
//  - Reset: rst=1 for 2 cycles with both valids high -> no ready, rsp_valid=0; first tie after reset
//    grants port 0.
//  - Single ADD: p0 op=0010 a=6'h3F b=6'h01, rsp_ready=1 -> next cycle rsp_out=0, carry=1, zero=1, id=0.
//  - Contention: both valid every cycle, rsp_ready=1, p0 SUB 5-7, p1 SLT a=6'h20 b=6'h01
//    -> alternating ids 0,1,0,1; SUB out=6'h3E carry=1; SLT out=1.
//  - Backpressure: rsp_ready=0 for 3 cycles while FULL -> both readies 0, rsp_* stable.
//    rsp_ready=1 then -> take and accept in the same cycle.
//  - Shift edges: SRA a=6'h24 b=6'd7 -> 6'h3F; SRL same operands -> 0; SLL a=6'h01 b=3 -> 6'h08.
//  - Illegal op=1111 -> out=0, zero=1, illegal=1, carry=0. Assert rst while FULL -> rsp_valid=0 next cycle.

Source files
------------

// File: rtl/alu_rr_arbiter_pkg.sv
// Shared definitions for the round-robin ALU arbiter: op codes, default width, FSM states.
package alu_rr_arbiter_pkg;

   localparam int ALU_W = 6;

   typedef enum logic [3:0] {
      OP_AND = 4'b0000,
      OP_OR  = 4'b0001,
      OP_ADD = 4'b0010,
      OP_SLL = 4'b0011,
      OP_XOR = 4'b0100,
      OP_SRL = 4'b0101,
      OP_SUB = 4'b0110,
      OP_SRA = 4'b0111,
      OP_SLT = 4'b1000
   } alu_op_e;

   typedef enum logic {
      RSP_EMPTY = 1'b0,
      RSP_FULL  = 1'b1
   } rsp_state_e;

endpackage

// File: rtl/alu_rr_arbiter_alu_core.sv
// Combinational ALU shared by both requesters; undefined op codes flag illegal and yield 0.
module alu_core
   import alu_rr_arbiter_pkg::*;
#(
   parameter int WIDTH = ALU_W
) (
   input  logic [3:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] out_o,
   output logic             carry_o,
   output logic             zero_o,
   output logic             illegal_o
);

   localparam int SHW = $clog2(WIDTH);

   logic [SHW-1:0] sh;
   logic           sh_big;
   logic [WIDTH:0] sum;
   logic [WIDTH:0] dif;

   assign sh     = b_i[SHW-1:0];
   assign sh_big = int'(sh) >= WIDTH;
   assign sum    = {1'b0, a_i} + {1'b0, b_i};
   assign dif    = {1'b0, a_i} - {1'b0, b_i};

   // Op decode; shifts past the operand width saturate to 0 (logical) or sign fill (arithmetic)
   always_comb begin
      out_o     = '0;
      carry_o   = 1'b0;
      illegal_o = 1'b0;
      case (op_i)
         OP_AND: out_o = a_i & b_i;
         OP_OR:  out_o = a_i | b_i;
         OP_XOR: out_o = a_i ^ b_i;
         OP_ADD: begin
            out_o   = sum[WIDTH-1:0];
            carry_o = sum[WIDTH];
         end
         OP_SUB: begin
            out_o   = dif[WIDTH-1:0];
            carry_o = dif[WIDTH];
         end
         OP_SLL: out_o = sh_big ? '0 : (a_i << sh);
         OP_SRL: out_o = sh_big ? '0 : (a_i >> sh);
         OP_SRA: out_o = sh_big ? {WIDTH{a_i[WIDTH-1]}} : WIDTH'($signed(a_i) >>> sh);
         OP_SLT: out_o = {{(WIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)};
         default: illegal_o = 1'b1;
      endcase
   end

   assign zero_o = (out_o == '0);

endmodule

// File: rtl/alu_rr_arbiter.sv
// Two-port round-robin front end to one shared ALU with a single-entry tagged response buffer.
module alu_rr_arbiter
   import alu_rr_arbiter_pkg::*;
#(
   parameter int WIDTH = ALU_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_out,
   output logic             rsp_carry,
   output logic             rsp_zero,
   output logic             rsp_illegal
);

   rsp_state_e       state_q, state_d;
   logic             last_grant_q;
   logic             id_q;
   logic [WIDTH-1:0] out_q;
   logic             carry_q, zero_q, illegal_q;

   logic             gnt_vld, gnt_id, can_accept, accept;
   logic [3:0]       sel_op;
   logic [WIDTH-1:0] sel_a, sel_b, alu_out;
   logic             alu_carry, alu_zero, alu_illegal;

   // Grant: a lone requester wins; on a tie the port not granted last time wins
   assign gnt_vld    = req0_valid | req1_valid;
   assign gnt_id     = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
   assign can_accept = (state_q == RSP_EMPTY) | rsp_ready;
   assign accept     = gnt_vld & can_accept & ~rst;
   assign req0_ready = can_accept & ~rst & gnt_vld & ~gnt_id;
   assign req1_ready = can_accept & ~rst & gnt_vld & gnt_id;

   assign sel_op = gnt_id ? req1_op : req0_op;
   assign sel_a  = gnt_id ? req1_a  : req0_a;
   assign sel_b  = gnt_id ? req1_b  : req0_b;

   alu_core #(.WIDTH(WIDTH)) u_alu (
      .op_i      (sel_op),
      .a_i       (sel_a),
      .b_i       (sel_b),
      .out_o     (alu_out),
      .carry_o   (alu_carry),
      .zero_o    (alu_zero),
      .illegal_o (alu_illegal)
   );

   // Buffer occupancy: fill on accept, drain on take unless refilled in the same cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         RSP_EMPTY: if (accept) state_d = RSP_FULL;
         RSP_FULL:  if (rsp_ready && !accept) state_d = RSP_EMPTY;
         default:   state_d = RSP_EMPTY;
      endcase
   end

   // State, round-robin pointer and response payload registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RSP_EMPTY;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         out_q        <= '0;
         carry_q      <= 1'b0;
         zero_q       <= 1'b0;
         illegal_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            last_grant_q <= gnt_id;
            id_q         <= gnt_id;
            out_q        <= alu_out;
            carry_q      <= alu_carry;
            zero_q       <= alu_zero;
            illegal_q    <= alu_illegal;
         end
      end
   end

   assign rsp_valid   = (state_q == RSP_FULL);
   assign rsp_id      = id_q;
   assign rsp_out     = out_q;
   assign rsp_carry   = carry_q;
   assign rsp_zero    = zero_q;
   assign rsp_illegal = illegal_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench: stimulus pushes hand-computed responses into a queue, a monitor pops on each take.
module tb_alu_rr_arbiter;

   localparam int W = 6;

   typedef struct packed {
      logic         id;
      logic [W-1:0] out;
      logic         carry;
      logic         zero;
      logic         illegal;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0]   req0_op, req1_op;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_zero, rsp_illegal;
   logic [W-1:0] rsp_out;

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   alu_rr_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out),
      .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Monitor: every take of the response buffer is compared against the oldest expectation
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         exp_t e, g;
         g = '{id: rsp_id, out: rsp_out, carry: rsp_carry, zero: rsp_zero, illegal: rsp_illegal};
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL rsp_unexpected: got %0h want none", g);
         end else begin
            e = sb.pop_front();
            if (g !== e) begin
               bad++;
               $display("FAIL rsp: got id=%0d out=%0h c=%0d z=%0d ill=%0d want id=%0d out=%0h c=%0d z=%0d ill=%0d",
                        g.id, g.out, g.carry, g.zero, g.illegal, e.id, e.out, e.carry, e.zero, e.illegal);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Port 0 single issue: hold until ready seen (bounded), then drop valid after the edge
   task automatic issue0(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
      int n;
      req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
      sb.push_back(e);
      n = 0;
      @(negedge clk);
      while (!req0_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         total++; bad++;
         $display("FAIL issue0_timeout: got ready=0 want ready=1");
      end
      tick();
      req0_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 6'h3F; req0_b = 6'h01;
      req1_valid = 1'b1; req1_op = 4'b0000; req1_a = 6'h2A; req1_b = 6'h0F;

      // reset with both valids high
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_ready0", 32'(req0_ready), 0);
         chk("rst_ready1", 32'(req1_ready), 0);
         chk("rst_rsp_valid", 32'(rsp_valid), 0);
         chk("rst_rsp_out", 32'(rsp_out), 0);
      end
      tick();
      rst = 1'b0;

      // first tie goes to port 0: ADD 3F+01 wraps to 0 with carry
      sb.push_back('{id: 1'b0, out: 6'h00, carry: 1'b1, zero: 1'b1, illegal: 1'b0});
      sb.push_back('{id: 1'b1, out: 6'h0A, carry: 1'b0, zero: 1'b0, illegal: 1'b0});
      @(negedge clk);
      chk("tie_ready0", 32'(req0_ready), 1);
      chk("tie_ready1", 32'(req1_ready), 0);
      tick();
      req0_valid = 1'b0;
      @(negedge clk);
      chk("p1_ready", 32'(req1_ready), 1);
      tick();
      req1_valid = 1'b0;
      repeat (2) tick();

      // contention: p0 SUB 5-7, p1 SLT -32<1; last winner was port 1
      req0_op = 4'b0110; req0_a = 6'd5;  req0_b = 6'd7;
      req1_op = 4'b1000; req1_a = 6'h20; req1_b = 6'h01;
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) sb.push_back('{id: 1'b0, out: 6'h3E, carry: 1'b1, zero: 1'b0, illegal: 1'b0});
         else            sb.push_back('{id: 1'b1, out: 6'h01, carry: 1'b0, zero: 1'b0, illegal: 1'b0});
      end
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("alt_ready0", 32'(req0_ready), (k % 2 == 0) ? 1 : 0);
         chk("alt_ready1", 32'(req1_ready), (k % 2 == 1) ? 1 : 0);
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (2) tick();

      // backpressure: XOR held in buffer while p1 OR waits
      rsp_ready = 1'b0;
      req0_op = 4'b0100; req0_a = 6'h15; req0_b = 6'h0F; req0_valid = 1'b1;
      sb.push_back('{id: 1'b0, out: 6'h1A, carry: 1'b0, zero: 1'b0, illegal: 1'b0});
      sb.push_back('{id: 1'b1, out: 6'h33, carry: 1'b0, zero: 1'b0, illegal: 1'b0});
      @(negedge clk);
      chk("bp_accept0", 32'(req0_ready), 1);
      tick();
      req0_valid = 1'b0;
      req1_op = 4'b0001; req1_a = 6'h30; req1_b = 6'h03; req1_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_ready0", 32'(req0_ready), 0);
         chk("bp_ready1", 32'(req1_ready), 0);
         chk("bp_valid", 32'(rsp_valid), 1);
         chk("bp_out", 32'(rsp_out), 32'h1A);
         chk("bp_id", 32'(rsp_id), 0);
         tick();
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_take_accept", 32'(req1_ready), 1);
      tick();
      req1_valid = 1'b0;
      repeat (2) tick();

      // shift edges, in-range SRA, illegal op
      issue0(4'b0111, 6'h24, 6'd7, '{id: 1'b0, out: 6'h3F, carry: 1'b0, zero: 1'b0, illegal: 1'b0});
      issue0(4'b0101, 6'h24, 6'd7, '{id: 1'b0, out: 6'h00, carry: 1'b0, zero: 1'b1, illegal: 1'b0});
      issue0(4'b0011, 6'h01, 6'd3, '{id: 1'b0, out: 6'h08, carry: 1'b0, zero: 1'b0, illegal: 1'b0});
      issue0(4'b0111, 6'h24, 6'd2, '{id: 1'b0, out: 6'h39, carry: 1'b0, zero: 1'b0, illegal: 1'b0});
      issue0(4'b1111, 6'h05, 6'd3, '{id: 1'b0, out: 6'h00, carry: 1'b0, zero: 1'b1, illegal: 1'b1});
      repeat (2) tick();

      // reset while FULL drops the buffered ADD 1+2
      rsp_ready = 1'b0;
      req0_op = 4'b0010; req0_a = 6'd1; req0_b = 6'd2; req0_valid = 1'b1;
      tick();
      req0_valid = 1'b0;
      @(negedge clk);
      chk("full_valid", 32'(rsp_valid), 1);
      chk("full_out", 32'(rsp_out), 3);
      tick();
      rst = 1'b1;
      tick();
      @(negedge clk);
      chk("rst_full_valid", 32'(rsp_valid), 0);
      chk("rst_full_out", 32'(rsp_out), 0);
      tick();
      rst = 1'b0; rsp_ready = 1'b1;
      repeat (3) tick();
      chk("sb_drained", 32'(sb.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global bound so a stalled DUT still reaches a verdict
   initial begin
      #50000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
